hwgen_ifg_scheduler: RTL and testbench

Replay scheduler for the pcap2hwgen output path: consumes one hwgen header per packet (length, inter-frame gap in cycles) and gates the 128-bit packet data stream so each packet leaves exactly IFG idle cycles after the previous one. It sits between the header creator / packet FIFO and the traffic-generator output port. It also enforces per-packet beat count against the header length.

---
 rtl/hwgen_ifg_scheduler_pkg.sv | 17 +
 rtl/hwgen_ifg_scheduler_if.sv | 37 +++
 rtl/hwgen_gap_timer.sv | 34 +++
 rtl/hwgen_ifg_scheduler.sv | 157 +++++++++++++++
 tb/tb_hwgen_ifg_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwgen_ifg_scheduler_pkg.sv
// Shared types and helpers for the hwgen inter-frame-gap replay scheduler.
package hwgen_ifg_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SEND = 2'd2
    } hwgen_sched_state_t;

    localparam int unsigned GAP_COMP_C = 2;

    // 16-byte beats needed to carry len bytes (partial last beat rounds up)
    function automatic logic [31:0] beats_from_len(input logic [31:0] len);
        return {4'd0, len[31:4]} + {31'd0, (len[3:0] != 4'd0)};
    endfunction

endpackage

// File: rtl/hwgen_ifg_scheduler_if.sv
// Header and packet-stream bundle of the IFG scheduler; master = scheduler side.
interface hwgen_ifg_scheduler_if;

    logic         HDR_TVALID;
    logic         HDR_TREADY;
    logic [31:0]  HDR_LEN;
    logic [31:0]  HDR_IFG;

    logic         S_TVALID;
    logic         S_TREADY;
    logic [127:0] S_TDATA;
    logic [15:0]  S_TSTRB;
    logic         S_TLAST;

    logic         M_TVALID;
    logic         M_TREADY;
    logic [127:0] M_TDATA;
    logic [15:0]  M_TSTRB;
    logic         M_TLAST;

    modport master (
        input  HDR_TVALID, HDR_LEN, HDR_IFG,
        input  S_TVALID, S_TDATA, S_TSTRB, S_TLAST,
        input  M_TREADY,
        output HDR_TREADY, S_TREADY,
        output M_TVALID, M_TDATA, M_TSTRB, M_TLAST
    );

    modport slave (
        output HDR_TVALID, HDR_LEN, HDR_IFG,
        output S_TVALID, S_TDATA, S_TSTRB, S_TLAST,
        output M_TREADY,
        input  HDR_TREADY, S_TREADY,
        input  M_TVALID, M_TDATA, M_TSTRB, M_TLAST
    );

endinterface

// File: rtl/hwgen_gap_timer.sv
// Loadable gap down-counter: loads IFG minus the fixed scheduler overhead (floored at 0).
module hwgen_gap_timer #(
    parameter int unsigned GAP_COMP = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        load,
    input  logic [31:0] ifg,
    input  logic        force_zero,
    input  logic        dec,
    output logic        zero
);

    logic [31:0] count;
    logic [31:0] load_val;

    always_comb begin
        load_val = '0;
        if (!force_zero && (ifg > 32'(GAP_COMP)))
            load_val = ifg - 32'(GAP_COMP);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 32'd1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hwgen_ifg_scheduler.sv
// IFG replay scheduler: gates the packet stream so each packet leaves HDR_IFG idle cycles
// after the previous one. Define HWGEN_SCHED_STATS_EN to build the PKT_COUNT/GAP_CYCLES counters.
//
// state | meaning
// IDLE  | waiting for a header (HDR_TREADY = ENABLE)
// GAP   | gap timer counting down the inter-frame idle time
// SEND  | packet beats pass through until TLAST or expected beat count
module hwgen_ifg_scheduler
    import hwgen_ifg_scheduler_pkg::*;
#(
    parameter int unsigned GAP_COMP = GAP_COMP_C
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic                  ERR_CLR,
    hwgen_ifg_scheduler_if.master bus,
    output logic                  BUSY,
    output logic                  LEN_ERR,
    output logic [31:0]           PKT_COUNT,
    output logic [31:0]           GAP_CYCLES
);

    hwgen_sched_state_t state, state_nxt;

    logic        enable_q;
    logic        first_pkt;
    logic [31:0] beat_cnt;
    logic [31:0] exp_beats;
    logic        gap_zero;

    logic        hdr_fire;
    logic        hdr_load;
    logic        hdr_len_zero;
    logic        enable_rise;
    logic        first_eff;
    logic        beat_fire;
    logic [31:0] beat_num;
    logic        end_by_cnt;
    logic        end_by_last;
    logic        pkt_end;
    logic        err_set;

    assign hdr_fire     = (state == IDLE) && ENABLE && bus.HDR_TVALID;
    assign hdr_len_zero = (bus.HDR_LEN == '0);
    assign hdr_load     = hdr_fire && !hdr_len_zero;
    assign enable_rise  = ENABLE && !enable_q;
    // a header taken on the very cycle ENABLE rises is already the first packet
    assign first_eff    = first_pkt || enable_rise;

    assign beat_fire    = (state == SEND) && bus.S_TVALID && bus.M_TREADY;
    assign beat_num     = beat_cnt + 32'd1;
    assign end_by_cnt   = (beat_num == exp_beats);
    assign end_by_last  = bus.S_TLAST;
    assign pkt_end      = beat_fire && (end_by_cnt || end_by_last);
    assign err_set      = (pkt_end && (end_by_cnt != end_by_last)) || (hdr_fire && hdr_len_zero);

    hwgen_gap_timer #(
        .GAP_COMP (GAP_COMP)
    ) u_gap_timer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load       (hdr_load),
        .ifg        (bus.HDR_IFG),
        .force_zero (first_eff),
        .dec        (state == GAP),
        .zero       (gap_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.HDR_TREADY = 1'b0;
        bus.S_TREADY   = 1'b0;
        bus.M_TVALID   = 1'b0;
        bus.M_TLAST    = 1'b0;
        case (state)
            IDLE: begin
                bus.HDR_TREADY = ENABLE;
                if (hdr_load)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_zero)
                    state_nxt = SEND;
            end
            SEND: begin
                bus.M_TVALID = bus.S_TVALID;
                bus.S_TREADY = bus.M_TREADY;
                bus.M_TLAST  = bus.S_TVALID && (end_by_last || end_by_cnt);
                if (pkt_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.M_TDATA = bus.S_TDATA;
    assign bus.M_TSTRB = bus.S_TSTRB;
    assign BUSY        = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            enable_q  <= 1'b0;
            first_pkt <= 1'b1;
            beat_cnt  <= '0;
            exp_beats <= '0;
            LEN_ERR   <= 1'b0;
        end else begin
            enable_q <= ENABLE;
            if (hdr_load)
                first_pkt <= 1'b0;
            else if (enable_rise)
                first_pkt <= 1'b1;
            if (hdr_load) begin
                beat_cnt  <= '0;
                exp_beats <= beats_from_len(bus.HDR_LEN);
            end else if (beat_fire) begin
                beat_cnt <= beat_num;
            end
            if (err_set)
                LEN_ERR <= 1'b1;
            else if (ERR_CLR)
                LEN_ERR <= 1'b0;
        end
    end

`ifdef HWGEN_SCHED_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] gap_cycles_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pkt_count_q  <= '0;
            gap_cycles_q <= '0;
        end else begin
            if (pkt_end)
                pkt_count_q <= pkt_count_q + 32'd1;
            if (state == GAP)
                gap_cycles_q <= gap_cycles_q + 32'd1;
        end
    end

    assign PKT_COUNT  = pkt_count_q;
    assign GAP_CYCLES = gap_cycles_q;
`else
    assign PKT_COUNT  = '0;
    assign GAP_CYCLES = '0;
`endif

endmodule

// File: tb/tb_hwgen_ifg_scheduler.sv
// Scoreboard bench for hwgen_ifg_scheduler: driver queues expected beats, monitor checks output.
module tb_hwgen_ifg_scheduler;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
        int           gap;
        int           lat;
    } exp_t;

    logic CLK;
    logic RST_N;
    logic ENABLE;
    logic ERR_CLR;
    logic BUSY;
    logic LEN_ERR;
    logic [31:0] PKT_COUNT;
    logic [31:0] GAP_CYCLES;
    logic tog_en;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hdr_acc_cyc = 0;
    int last_end    = -1000;
    exp_t exp_q[$];

    hwgen_ifg_scheduler_if bus();

    hwgen_ifg_scheduler dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .ERR_CLR    (ERR_CLR),
        .bus        (bus),
        .BUSY       (BUSY),
        .LEN_ERR    (LEN_ERR),
        .PKT_COUNT  (PKT_COUNT),
        .GAP_CYCLES (GAP_CYCLES)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] pat(input int id, input int k);
        return {32'(id), 32'(k), 32'hC0DE5A5A, 32'(id * 16 + k)};
    endfunction

    function automatic logic [15:0] spat(input int id, input int k);
        return 16'(k * 5 + id * 257);
    endfunction

    initial begin
        bus.M_TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            bus.M_TREADY = tog_en ? ~bus.M_TREADY : 1'b1;
        end
    end

    // monitor: pops one expectation per output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (bus.M_TVALID)
                    chkn("s_tready_mirror", int'(bus.S_TREADY), int'(bus.M_TREADY));
                if (bus.M_TVALID && bus.M_TREADY) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", bus.M_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_tdata", bus.M_TDATA, e.data);
                        chk("m_tstrb", 128'(bus.M_TSTRB), 128'(e.strb));
                        chkn("m_tlast", int'(bus.M_TLAST), int'(e.last));
                        if (e.gap >= 0)
                            chkn("ifg_idle_cycles", cyc - last_end - 1, e.gap);
                        if (e.lat >= 0)
                            chkn("hdr_to_valid", cyc - hdr_acc_cyc, e.lat);
                    end
                    if (bus.M_TLAST)
                        last_end = cyc;
                end
            end
        end
    end

    task automatic send_pkt(input int id, input logic [31:0] len, input logic [31:0] ifg,
                            input int nout, input int tlast_pos, input int gap, input int lat,
                            input int drop_en_beat);
        exp_t e;
        bit ok;
        for (int k = 1; k <= nout; k++) begin
            e.data = pat(id, k);
            e.strb = spat(id, k);
            e.last = (k == nout);
            e.gap  = (k == 1) ? gap : -1;
            e.lat  = (k == 1) ? lat : -1;
            exp_q.push_back(e);
        end
        bus.HDR_LEN    = len;
        bus.HDR_IFG    = ifg;
        bus.HDR_TVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (bus.HDR_TREADY) begin
                hdr_acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.HDR_TVALID = 1'b0;
        chkn("hdr_accept", int'(ok), 1);
        for (int k = 1; k <= nout; k++) begin
            if (k == drop_en_beat)
                ENABLE = 1'b0;
            bus.S_TVALID = 1'b1;
            bus.S_TDATA  = pat(id, k);
            bus.S_TSTRB  = spat(id, k);
            bus.S_TLAST  = (k == tlast_pos);
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge CLK);
                if (bus.S_TREADY) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge CLK);
            #1;
            chkn("beat_accept", int'(ok), 1);
            if (!ok)
                break;
        end
        bus.S_TVALID = 1'b0;
        bus.S_TLAST  = 1'b0;
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
        chkn("len_err_cleared", int'(LEN_ERR), 0);
    endtask

    initial begin
        bit ok;
        int exp_pkts_pre;
        int exp_pkts_post;
        int exp_gap_post;
`ifdef HWGEN_SCHED_STATS_EN
        exp_pkts_pre  = 8;
        exp_pkts_post = 1;
        exp_gap_post  = 1;
`else
        exp_pkts_pre  = 0;
        exp_pkts_post = 0;
        exp_gap_post  = 0;
`endif
        RST_N = 1'b0;
        ENABLE = 1'b0;
        ERR_CLR = 1'b0;
        tog_en = 1'b0;
        bus.HDR_TVALID = 1'b0;
        bus.HDR_LEN = '0;
        bus.HDR_IFG = '0;
        bus.S_TVALID = 1'b0;
        bus.S_TDATA = '0;
        bus.S_TSTRB = '0;
        bus.S_TLAST = 1'b0;
        #3;
        chkn("rst_hdr_tready", int'(bus.HDR_TREADY), 0);
        chkn("rst_s_tready", int'(bus.S_TREADY), 0);
        chkn("rst_m_tvalid", int'(bus.M_TVALID), 0);
        chkn("rst_m_tlast", int'(bus.M_TLAST), 0);
        chkn("rst_busy", int'(BUSY), 0);
        chkn("rst_len_err", int'(LEN_ERR), 0);
        chkn("rst_pkt_count", int'(PKT_COUNT), 0);
        chkn("rst_gap_cycles", int'(GAP_CYCLES), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        ENABLE = 1'b1;

        // first packet: IFG ignored, valid 2 cycles after header accept
        send_pkt(1, 32'd64, 32'd100, 4, 4, -1, 2, 0);
        send_pkt(2, 32'd32, 32'd10, 2, 2, 10, -1, 0);
        send_pkt(3, 32'd32, 32'd1, 2, 2, 2, -1, 0);

        // early TLAST on a 3-beat header
        send_pkt(4, 32'd48, 32'd0, 2, 2, 2, -1, 0);
        chkn("len_err_early_last", int'(LEN_ERR), 1);
        chkn("busy_after_early_last", int'(BUSY), 0);
        clear_err();

        // no TLAST: 17 bytes -> forced end on beat 2
        send_pkt(5, 32'd17, 32'd3, 2, 0, -1, -1, 0);
        chkn("len_err_forced_last", int'(LEN_ERR), 1);
        clear_err();

        // zero-length header is consumed and flagged
        send_pkt(6, 32'd0, 32'd5, 0, 0, -1, -1, 0);
        chkn("len_err_zero_len", int'(LEN_ERR), 1);
        chkn("busy_zero_len", int'(BUSY), 0);
        clear_err();

        tog_en = 1'b1;
        send_pkt(7, 32'd80, 32'd4, 5, 5, -1, -1, 0);
        tog_en = 1'b0;

        // ENABLE dropped at beat 2: packet completes, next header blocked
        send_pkt(8, 32'd64, 32'd7, 4, 4, -1, -1, 2);
        bus.HDR_LEN = 32'd16;
        bus.HDR_IFG = 32'd0;
        bus.HDR_TVALID = 1'b1;
        repeat (5) @(negedge CLK);
        chkn("hdr_tready_disabled", int'(bus.HDR_TREADY), 0);
        chkn("busy_disabled", int'(BUSY), 0);
        @(posedge CLK);
        #1;
        bus.HDR_TVALID = 1'b0;
        ENABLE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        send_pkt(9, 32'd16, 32'd50, 1, 1, -1, 2, 0);
        chkn("pkt_count_before_reset", int'(PKT_COUNT), exp_pkts_pre);

        // reset while waiting out a long gap
        bus.HDR_LEN = 32'd32;
        bus.HDR_IFG = 32'd100;
        bus.HDR_TVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.HDR_TREADY) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.HDR_TVALID = 1'b0;
        chkn("gap_hdr_accept", int'(ok), 1);
        repeat (5) @(negedge CLK);
        chkn("busy_in_gap", int'(BUSY), 1);
        chkn("m_tvalid_in_gap", int'(bus.M_TVALID), 0);
        RST_N = 1'b0;
        #1;
        chkn("arst_busy", int'(BUSY), 0);
        chkn("arst_m_tvalid", int'(bus.M_TVALID), 0);
        chkn("arst_s_tready", int'(bus.S_TREADY), 0);
        chkn("arst_len_err", int'(LEN_ERR), 0);
        chkn("arst_pkt_count", int'(PKT_COUNT), 0);
        chkn("arst_gap_cycles", int'(GAP_CYCLES), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        send_pkt(10, 32'd16, 32'd9, 1, 1, -1, 2, 0);
        chkn("pkt_count_after_reset", int'(PKT_COUNT), exp_pkts_post);
        chkn("gap_cycles_after_reset", int'(GAP_CYCLES), exp_gap_post);

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0)
                break;
            @(posedge CLK);
        end
        chkn("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
